// File: rtl/p66_pkg.sv
// Shared 64b/66b definitions: sync headers, default thresholds and the RX block-sync state encoding.
package p66_pkg;

  localparam logic [1:0] SYNC_DATA    = 2'b01;
  localparam logic [1:0] SYNC_CONTROL = 2'b10;

  localparam int LOCK_CNT_DEF   = 64;
  localparam int BAD_LIMIT_DEF  = 16;
  localparam int SLIP_WAIT_DEF  = 32;
  localparam int BER_WINDOW_DEF = 19531;
  localparam int BER_LIMIT_DEF  = 16;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    LOCKED = 2'd1,
    SLIP   = 2'd2
  } sync_state_e;

  function automatic logic hdr_valid(input logic [1:0] hdr);
    return (hdr == SYNC_DATA) || (hdr == SYNC_CONTROL);
  endfunction

endpackage

// File: rtl/p66_descrambler.sv
// Parallel 64-bit self-synchronising descrambler for x^58+x^39+1; payload bit 0 is first on the wire.
module p66_descrambler (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  input  logic [63:0] scr,
  output logic [63:0] dscr
);

  logic [57:0]  hist_q;
  logic [57:0]  hist_d;
  logic [121:0] ext;

  // ext[57] is the most recent previous scrambled bit, ext[58+i] is payload bit i
  always_comb begin
    ext    = {scr, hist_q};
    dscr   = '0;
    for (int i = 0; i < 64; i++) begin
      dscr[i] = ext[58+i] ^ ext[19+i] ^ ext[i];
    end
    hist_d = valid ? scr[63:6] : hist_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) hist_q <= '0;
    else     hist_q <= hist_d;
  end

endmodule

// File: rtl/p66_rxsync.sv
// 64b/66b receive block synchroniser: header-based lock FSM with gearbox slip, BER monitor, descrambler.
module p66_rxsync
  import p66_pkg::*;
#(
  parameter int LOCK_CNT   = LOCK_CNT_DEF,
  parameter int BAD_LIMIT  = BAD_LIMIT_DEF,
  parameter int SLIP_WAIT  = SLIP_WAIT_DEF,
  parameter int BER_WINDOW = BER_WINDOW_DEF,
  parameter int BER_LIMIT  = BER_LIMIT_DEF
) (
  input  logic        RX_CLK,
  input  logic        i_reset,
  input  logic        i_valid,
  input  logic [65:0] i_data,
  output logic        o_slip,
  output logic        o_valid,
  output logic [65:0] o_data,
  output logic        o_block_lock,
  output logic        o_hi_ber,
  output logic        o_phy_fault
);

  localparam int SH_W  = $clog2(LOCK_CNT + 1);
  localparam int BAD_W = $clog2(BAD_LIMIT + 1);
  localparam int SW_W  = $clog2(SLIP_WAIT + 1);
  localparam int BT_W  = $clog2(BER_WINDOW + 1);
  localparam int BC_W  = $clog2(BER_LIMIT + 1);

  sync_state_e state_q, state_d;
  logic [SH_W-1:0]  sh_cnt_q, sh_cnt_d;
  logic [BAD_W-1:0] bad_cnt_q, bad_cnt_d;
  logic [SW_W-1:0]  slip_cnt_q, slip_cnt_d;
  logic [BT_W-1:0]  ber_tmr_q, ber_tmr_d;
  logic [BC_W-1:0]  bcount_q, bcount_d;
  logic             slip_q, slip_d;
  logic             valid_q, valid_d;
  logic [65:0]      data_q, data_d;
  logic             lock_q, lock_d;
  logic             hi_ber_q, hi_ber_d;
  logic             fault_q, fault_d;

  logic [63:0] dscr;
  logic        bad_hdr;
  logic        ber_end;
  logic        ber_hit;

  p66_descrambler u_dscr (
    .clk   (RX_CLK),
    .rst   (i_reset),
    .valid (i_valid),
    .scr   (i_data[65:2]),
    .dscr  (dscr)
  );

  always_comb begin
    state_d    = state_q;
    sh_cnt_d   = sh_cnt_q;
    bad_cnt_d  = bad_cnt_q;
    slip_cnt_d = slip_cnt_q;
    bcount_d   = bcount_q;
    hi_ber_d   = hi_ber_q;
    lock_d     = lock_q;
    slip_d     = 1'b0;
    valid_d    = i_valid && (state_q == LOCKED);
    data_d     = i_valid ? {dscr, i_data[1:0]} : data_q;

    bad_hdr   = !hdr_valid(i_data[1:0]);
    ber_end   = (ber_tmr_q == BT_W'(BER_WINDOW - 1));
    ber_tmr_d = ber_end ? '0 : ber_tmr_q + 1'b1;
    ber_hit   = i_valid && (state_q == LOCKED) && bad_hdr;

    // A hit on the window-end clock opens the new window's count
    if (ber_end) begin
      if (bcount_q < BC_W'(BER_LIMIT)) hi_ber_d = 1'b0;
      bcount_d = ber_hit ? BC_W'(1) : '0;
    end else if (ber_hit && (bcount_q != BC_W'(BER_LIMIT))) begin
      bcount_d = bcount_q + 1'b1;
      if (bcount_q == BC_W'(BER_LIMIT - 1)) hi_ber_d = 1'b1;
    end

    // FSM placed after the BER logic so that losing lock overrides its updates
    if (i_valid) begin
      unique case (state_q)
        HUNT: begin
          if (bad_hdr) begin
            state_d  = SLIP;
            slip_d   = 1'b1;
            sh_cnt_d = '0;
          end else if (sh_cnt_q == SH_W'(LOCK_CNT - 1)) begin
            state_d   = LOCKED;
            lock_d    = 1'b1;
            sh_cnt_d  = '0;
            bad_cnt_d = '0;
          end else begin
            sh_cnt_d = sh_cnt_q + 1'b1;
          end
        end
        LOCKED: begin
          if (bad_hdr && (bad_cnt_q == BAD_W'(BAD_LIMIT - 1))) begin
            state_d   = SLIP;
            slip_d    = 1'b1;
            lock_d    = 1'b0;
            sh_cnt_d  = '0;
            bad_cnt_d = '0;
            bcount_d  = '0;
            hi_ber_d  = 1'b0;
          end else if (sh_cnt_q == SH_W'(LOCK_CNT - 1)) begin
            sh_cnt_d  = '0;
            bad_cnt_d = '0;
          end else begin
            sh_cnt_d  = sh_cnt_q + 1'b1;
            bad_cnt_d = bad_cnt_q + BAD_W'(bad_hdr);
          end
        end
        SLIP: begin
          if (slip_cnt_q == SW_W'(SLIP_WAIT - 1)) begin
            state_d    = HUNT;
            slip_cnt_d = '0;
            sh_cnt_d   = '0;
            bad_cnt_d  = '0;
          end else begin
            slip_cnt_d = slip_cnt_q + 1'b1;
          end
        end
        default: state_d = HUNT;
      endcase
    end

    fault_d = !lock_d || hi_ber_d;
  end

  always_ff @(posedge RX_CLK or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= HUNT;
      sh_cnt_q   <= '0;
      bad_cnt_q  <= '0;
      slip_cnt_q <= '0;
      ber_tmr_q  <= '0;
      bcount_q   <= '0;
      slip_q     <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      lock_q     <= 1'b0;
      hi_ber_q   <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      sh_cnt_q   <= sh_cnt_d;
      bad_cnt_q  <= bad_cnt_d;
      slip_cnt_q <= slip_cnt_d;
      ber_tmr_q  <= ber_tmr_d;
      bcount_q   <= bcount_d;
      slip_q     <= slip_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      lock_q     <= lock_d;
      hi_ber_q   <= hi_ber_d;
      fault_q    <= fault_d;
    end
  end

  assign o_slip       = slip_q;
  assign o_valid      = valid_q;
  assign o_data       = data_q;
  assign o_block_lock = lock_q;
  assign o_hi_ber     = hi_ber_q;
  assign o_phy_fault  = fault_q;

endmodule
